// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / write-back stage.
package mem_wb_pkg;

    // Stage state: idle, or a data-memory request outstanding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_e;

    localparam int DMEM_ADDR_W = 16;

    // Word accesses only: any set byte-offset bit is a misaligned access
    function automatic logic misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_timer.sv
// Request-age counter: cleared while idle, counts edges with a request held,
// flags expiry on the edge that completes LIMIT request cycles.
module mem_wb_timer #(
    parameter int LIMIT = 255,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // During request cycle k the count holds k-1, so cycle LIMIT is the last one
    assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_wb.sv
// Memory-access / write-back stage: ALU write-back, branch redirect, and
// load/store over a req/ack data-memory handshake with timeout.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int ADDR_W         = DMEM_ADDR_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    input  logic [31:0]       result_i,
    input  logic [31:0]       st_data_i,
    input  logic [3:0]        rd_addr_i,
    input  logic              wb_en_i,
    input  logic              branch_en_i,
    input  logic              ctrl_ld_i,
    input  logic              ctrl_st_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              rf_we_o,
    output logic [3:0]        rf_waddr_o,
    output logic [31:0]       rf_wdata_o,
    output logic              br_taken_o,
    output logic [31:0]       br_target_o,
    output logic              align_err_o,
    output logic              mem_err_o
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q;
    logic                req_q, we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                ld_q, wb_q;
    logic [3:0]          rd_q;
    logic                rf_we_q, br_q, align_q, merr_q;
    logic [3:0]          rf_waddr_q;
    logic [31:0]         rf_wdata_q, br_tgt_q;
    logic                is_mem, tmr_expire;

    assign stall_o = (state_q != ST_IDLE);
    assign is_mem  = ctrl_ld_i | ctrl_st_i;

    mem_wb_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .clr_i    (!stall_o),
        .en_i     (stall_o),
        .expire_o (tmr_expire)
    );

    // Stage FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ld_q       <= 1'b0;
            wb_q       <= 1'b0;
            rd_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            br_q       <= 1'b0;
            br_tgt_q   <= '0;
            align_q    <= 1'b0;
            merr_q     <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            br_q    <= 1'b0;
            align_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (v_i) begin
                        if (is_mem) begin
                            if (misaligned(result_i[1:0])) begin
                                align_q <= 1'b1;
                            end else begin
                                // Load wins when both ld and st are set
                                state_q <= ST_MEM;
                                req_q   <= 1'b1;
                                we_q    <= ~ctrl_ld_i;
                                addr_q  <= result_i[ADDR_W+1:2];
                                wdata_q <= st_data_i;
                                ld_q    <= ctrl_ld_i;
                                wb_q    <= wb_en_i;
                                rd_q    <= rd_addr_i;
                            end
                        end else if (branch_en_i) begin
                            br_q     <= 1'b1;
                            br_tgt_q <= result_i;
                        end else if (wb_en_i) begin
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= rd_addr_i;
                            rf_wdata_q <= result_i;
                        end
                    end
                end
                ST_MEM: begin
                    // Ack beats a coincident expiry
                    if (dmem_ack_i) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        if (ld_q && wb_q) begin
                            rf_we_q    <= 1'b1;
                            rf_waddr_q <= rd_q;
                            rf_wdata_q <= dmem_rdata_i;
                        end
                    end else if (tmr_expire) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        merr_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign br_taken_o   = br_q;
    assign br_target_o  = br_tgt_q;
    assign align_err_o  = align_q;
    assign mem_err_o    = merr_q;

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: the driver pushes expected events per op,
// a negedge monitor pops and compares whenever the DUT shows an output.
module tb_mem_wb;

    localparam int T  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          v_i = 1'b0;
    logic [31:0]   result_i = '0, st_data_i = '0;
    logic [3:0]    rd_addr_i = '0;
    logic          wb_en_i = 1'b0, branch_en_i = 1'b0, ctrl_ld_i = 1'b0, ctrl_st_i = 1'b0;
    logic          stall_o, dmem_req_o, dmem_we_o;
    logic [AW-1:0] dmem_addr_o;
    logic [31:0]   dmem_wdata_o;
    logic          dmem_ack_i = 1'b0;
    logic [31:0]   dmem_rdata_i = '0;
    logic          rf_we_o;
    logic [3:0]    rf_waddr_o;
    logic [31:0]   rf_wdata_o;
    logic          br_taken_o;
    logic [31:0]   br_target_o;
    logic          align_err_o, mem_err_o;

    always #5 clk = ~clk;

    mem_wb #(.ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .result_i(result_i), .st_data_i(st_data_i),
        .rd_addr_i(rd_addr_i), .wb_en_i(wb_en_i), .branch_en_i(branch_en_i),
        .ctrl_ld_i(ctrl_ld_i), .ctrl_st_i(ctrl_st_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .br_taken_o(br_taken_o), .br_target_o(br_target_o),
        .align_err_o(align_err_o), .mem_err_o(mem_err_o)
    );

    typedef struct packed { logic [3:0] a; logic [31:0] d; } rf_t;
    typedef struct packed { logic we; logic [AW-1:0] addr; logic [31:0] wd; logic [7:0] dur; } rq_t;

    rf_t         rf_q[$];
    logic [31:0] br_q[$];
    rq_t         rq_q[$];
    int          align_cnt = 0;
    logic        exp_merr  = 1'b0;
    int          vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: output pulsed with nothing expected", nm);
    endtask

    // Monitor: compares every visible DUT output against the scoreboard
    rq_t cur;
    int  run = 0;
    initial begin
        rf_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
            end else begin
                chk("stall_vs_req", 32'(stall_o), 32'(dmem_req_o));
                chk("mem_err", 32'(mem_err_o), 32'(exp_merr));
                if (rf_we_o) begin
                    if (rf_q.size() == 0) bad("rf_we");
                    else begin
                        e = rf_q.pop_front();
                        chk("rf_waddr", 32'(rf_waddr_o), 32'(e.a));
                        chk("rf_wdata", rf_wdata_o, e.d);
                    end
                end
                if (br_taken_o) begin
                    if (br_q.size() == 0) bad("br_taken");
                    else chk("br_target", br_target_o, br_q.pop_front());
                end
                if (align_err_o) begin
                    if (align_cnt == 0) bad("align_err");
                    else align_cnt--;
                end
                if (dmem_req_o) begin
                    if (run == 0) begin
                        if (rq_q.size() == 0) bad("dmem_req");
                        else cur = rq_q.pop_front();
                    end
                    chk("dmem_we", 32'(dmem_we_o), 32'(cur.we));
                    chk("dmem_addr", 32'(dmem_addr_o), 32'(cur.addr));
                    chk("dmem_wdata", dmem_wdata_o, cur.wd);
                    run++;
                end else if (run > 0) begin
                    if (cur.dur != 0) chk("req_cycles", 32'(run), 32'(cur.dur));
                    run = 0;
                end
            end
        end
    end

    // Random op presented on the inputs while the stage is stalled
    task automatic junk();
        v_i         = 1'b1;
        ctrl_ld_i   = 1'($urandom);
        ctrl_st_i   = 1'($urandom);
        branch_en_i = 1'($urandom);
        wb_en_i     = 1'($urandom);
        rd_addr_i   = 4'($urandom);
        result_i    = $urandom;
        st_data_i   = $urandom;
    endtask

    // Issue one op; lat = MEM cycle carrying the ack (lat > T means no ack)
    task automatic issue(input bit ld, input bit st, input bit br, input bit wb,
                         input logic [3:0] rd, input logic [31:0] res, input logic [31:0] sd,
                         input int lat, input logic [31:0] rdv);
        bit mem, alg;
        rq_t r;
        mem = ld | st;
        alg = (res[1:0] == 2'b00);
        v_i = 1'b1; ctrl_ld_i = ld; ctrl_st_i = st; branch_en_i = br; wb_en_i = wb;
        rd_addr_i = rd; result_i = res; st_data_i = sd;
        dmem_ack_i = 1'($urandom);
        dmem_rdata_i = $urandom;
        if (mem && !alg) align_cnt++;
        else if (mem) begin
            r.we = ~ld; r.addr = res[AW+1:2]; r.wd = sd; r.dur = 8'((lat > T) ? T : lat);
            rq_q.push_back(r);
            if (ld && wb && lat <= T) rf_q.push_back('{a: rd, d: rdv});
        end else if (br) br_q.push_back(res);
        else if (wb) rf_q.push_back('{a: rd, d: res});
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        if (!(mem && alg)) chk("stall_no_mem", 32'(stall_o), 32'd0);
        if (mem && alg) begin
            if (lat <= T) begin
                repeat (lat - 1) begin junk(); @(posedge clk); #1; end
                junk();
                dmem_ack_i = 1'b1; dmem_rdata_i = rdv;
                @(posedge clk); #1;
                dmem_ack_i = 1'b0;
            end else begin
                repeat (T) begin junk(); @(posedge clk); #1; end
                exp_merr = 1'b1;
            end
        end
        v_i = 1'b0;
    endtask

    // Async reset while a load is outstanding
    task automatic reset_mid_mem();
        rq_t r;
        v_i = 1'b1; ctrl_ld_i = 1'b1; ctrl_st_i = 1'b0; branch_en_i = 1'b0; wb_en_i = 1'b1;
        rd_addr_i = 4'd1; result_i = 32'h400; st_data_i = 32'h77;
        r.we = 1'b0; r.addr = 16'h100; r.wd = 32'h77; r.dur = 8'd0;
        rq_q.push_back(r);
        @(posedge clk); #1;
        v_i = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", 32'(dmem_req_o), 32'd1);
        #2 rst = 1'b0;
        exp_merr = 1'b0;
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_addr", 32'(dmem_addr_o), 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_mem_err", 32'(mem_err_o), 32'd0);
        chk("rst_rf", {rf_we_o, rf_waddr_o, rf_wdata_o[26:0]}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        bit ld, st, br;
        int k;
        #12;
        chk("reset_req", 32'(dmem_req_o), 32'd0);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_outs", {rf_we_o, br_taken_o, align_err_o, mem_err_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        issue(0, 0, 0, 1, 4'd3, 32'h1234, 32'h0, 0, 32'h0);                 // ALU write
        issue(1, 0, 0, 1, 4'd5, 32'h100, 32'h0, 3, 32'hDEADBEEF);           // load, ack cycle 3
        issue(0, 1, 0, 0, 4'd0, 32'h40, 32'hA5A5, 1, 32'h0);                // store, 1-cycle memory
        issue(1, 0, 0, 1, 4'd7, 32'h200, 32'h0, T, 32'hCAFEF00D);           // ack at expiry edge
        issue(1, 0, 0, 1, 4'd2, 32'h102, 32'h0, 0, 32'h0);                  // misaligned load
        issue(0, 0, 1, 1, 4'd9, 32'h80000010, 32'h0, 0, 32'h0);             // branch, no rf write
        issue(0, 0, 0, 0, 4'd8, 32'h55, 32'h0, 0, 32'h0);                   // ALU without wb
        issue(1, 1, 0, 1, 4'd4, 32'h84, 32'h1111, 2, 32'h5555AAAA);         // ld+st -> load
        issue(0, 1, 0, 1, 4'd6, 32'h301, 32'h9, 0, 32'h0);                  // misaligned store
        issue(1, 0, 0, 1, 4'd6, 32'h300, 32'h0, T + 2, 32'h0);              // timeout
        issue(0, 0, 0, 1, 4'd1, 32'h42, 32'h0, 0, 32'h0);
        reset_mid_mem();
        issue(0, 0, 0, 1, 4'd3, 32'h1234, 32'h0, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            k   = int'($urandom_range(0, 9));
            ld  = (k < 3);
            st  = (k >= 2 && k < 5);
            br  = (k == 5) || (k == 9 && $urandom_range(0, 1) == 1);
            res = $urandom;
            if ((ld || st) && $urandom_range(0, 3) != 0) res[1:0] = 2'b00;
            issue(ld, st, br, 1'($urandom_range(0, 3) != 0), 4'($urandom), res, $urandom,
                  int'($urandom_range(1, T + 2)), $urandom);
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rf_q_drained", 32'(rf_q.size()), 32'd0);
        chk("br_q_drained", 32'(br_q.size()), 32'd0);
        chk("rq_q_drained", 32'(rq_q.size()), 32'd0);
        chk("align_drained", 32'(align_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
